// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: condition codes, flag positions and the
// conditional-execution controller state encoding.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

endpackage

// File: rtl/cond_exec_ctrl_cond_eval.sv
// ARM condition-field evaluator: cond + {N,Z,C,V} -> pass.
module cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic base;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Even codes test a base predicate, odd codes its inverse; AL's inverse is NV.
  always_comb begin
    base = 1'b0;
    unique case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
    pass = base ^ cond[0];
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller between ID and EXE: owns NZCV, resolves
// the ID condition, annuls failing instructions, flushes on taken branches
// and interlocks on flag-setting EXE instructions when bypass is disabled.
module cond_exec_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned FWD = 1,
  parameter int unsigned CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          id_valid,
  input  logic [3:0]    id_cond,
  input  logic          id_is_branch,
  input  logic          exe_valid,
  input  logic          exe_s,
  input  logic [3:0]    exe_flags,
  output logic          id_exec,
  output logic          id_kill,
  output logic          stall,
  output logic          branch_taken,
  output logic [3:0]    sr,
  output logic [CW-1:0] exec_cnt,
  output logic [CW-1:0] kill_cnt
);

  state_t     state, state_next;
  logic [3:0] eff_flags;
  logic       pass;
  logic       flag_hazard;
  logic       issue_slot;

  // Flags seen by the ID instruction: bypassed from EXE when enabled.
  always_comb begin
    flag_hazard = exe_valid & exe_s;
    eff_flags   = sr;
    if (FWD != 0 && flag_hazard) eff_flags = exe_flags;
  end

  cond_eval u_cond_eval (
    .cond  (id_cond),
    .flags (eff_flags),
    .pass  (pass)
  );

  // Next-state and issue/kill/stall/flush decisions.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    issue_slot   = 1'b0;
    id_exec      = 1'b0;
    id_kill      = 1'b0;
    branch_taken = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (FWD == 0 && id_valid && flag_hazard) stall = 1'b1;
        else                                     issue_slot = id_valid;
      end
      ST_WAIT:   issue_slot = id_valid;
      ST_SQUASH: issue_slot = 1'b0;
      default:   issue_slot = 1'b0;
    endcase
    id_exec      = issue_slot & pass;
    id_kill      = issue_slot & ~pass;
    branch_taken = id_exec & id_is_branch;
    if (branch_taken) state_next = ST_SQUASH;
    else if (stall)   state_next = ST_WAIT;
    else              state_next = ST_RUN;
  end

  // State register; holds while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         state <= ST_RUN;
    else if (!freeze) state <= state_next;
  end

  // Architectural NZCV, written by flag-setting EXE instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           sr <= '0;
    else if (!freeze && flag_hazard)    sr <= exe_flags;
  end

  // Issued / annulled event counters, wrapping modulo 2^CW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exec_cnt <= '0;
      kill_cnt <= '0;
    end else if (!freeze) begin
      if (id_exec) exec_cnt <= exec_cnt + CW'(1);
      if (id_kill) kill_cnt <= kill_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Scoreboard bench: one bypassing instance (FWD=1, CW=16) and one
// interlocking instance (FWD=0, CW=4) share stimulus; a reference model
// predicts every cycle and a negedge monitor compares.
module tb_cond_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        id_valid;
  logic [3:0]  id_cond;
  logic        id_is_branch;
  logic        exe_valid;
  logic        exe_s;
  logic [3:0]  exe_flags;

  logic        f_exec, f_kill, f_stall, f_taken;
  logic [3:0]  f_sr;
  logic [15:0] f_ec, f_kc;
  logic        s_exec, s_kill, s_stall, s_taken;
  logic [3:0]  s_sr;
  logic [3:0]  s_ec, s_kc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    bit          exec, kill, stall, taken;
    logic [3:0]  sr;
    int unsigned ec, kc;
  } exp_t;

  exp_t q_fwd[$];
  exp_t q_stl[$];

  // model state, index 1 = bypassing instance, 0 = interlocking instance
  logic [3:0]  m_sr[2];
  bit          m_squash[2];
  bit          m_wait[2];
  int unsigned m_ec[2];
  int unsigned m_kc[2];

  cond_exec_ctrl #(.FWD(1), .CW(16)) dut_fwd (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_cond(id_cond), .id_is_branch(id_is_branch), .exe_valid(exe_valid),
    .exe_s(exe_s), .exe_flags(exe_flags), .id_exec(f_exec), .id_kill(f_kill),
    .stall(f_stall), .branch_taken(f_taken), .sr(f_sr), .exec_cnt(f_ec),
    .kill_cnt(f_kc)
  );

  cond_exec_ctrl #(.FWD(0), .CW(4)) dut_stl (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_cond(id_cond), .id_is_branch(id_is_branch), .exe_valid(exe_valid),
    .exe_s(exe_s), .exe_flags(exe_flags), .id_exec(s_exec), .id_kill(s_kill),
    .stall(s_stall), .branch_taken(s_taken), .sr(s_sr), .exec_cnt(s_ec),
    .kill_cnt(s_kc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ARM condition table written out from the architectural definitions
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: apply inputs, predict both instances, advance model.
  task automatic step(input bit iv, input logic [3:0] c, input bit br,
                      input bit ev, input bit es, input logic [3:0] ef,
                      input bit frz, input bit r);
    @(posedge clk);
    #1;
    rst = r; freeze = frz; id_valid = iv; id_cond = c; id_is_branch = br;
    exe_valid = ev; exe_s = es; exe_flags = ef;
    for (int d = 0; d < 2; d++) begin
      bit          bypass;
      int unsigned mask;
      logic [3:0]  eff;
      bit          p, st, act;
      exp_t        e;
      bypass = (d == 1);
      mask   = (d == 1) ? 32'hFFFF : 32'hF;
      if (!r) begin
        m_sr[d] = 4'b0000; m_squash[d] = 0; m_wait[d] = 0; m_ec[d] = 0; m_kc[d] = 0;
      end
      eff     = (bypass && ev && es) ? ef : m_sr[d];
      p       = ref_pass(c, eff);
      st      = !m_squash[d] && !m_wait[d] && !bypass && iv && ev && es;
      act     = iv && !m_squash[d] && !st;
      e.exec  = act && p;
      e.kill  = act && !p;
      e.stall = st;
      e.taken = e.exec && br;
      e.sr    = m_sr[d];
      e.ec    = m_ec[d];
      e.kc    = m_kc[d];
      if (d == 1) q_fwd.push_back(e);
      else        q_stl.push_back(e);
      if (r && !frz) begin
        if (ev && es) m_sr[d] = ef;
        if (e.exec) m_ec[d] = (m_ec[d] + 1) & mask;
        if (e.kill) m_kc[d] = (m_kc[d] + 1) & mask;
        m_squash[d] = e.taken;
        m_wait[d]   = st;
      end
    end
  endtask

  // Monitor: every cycle with a prediction pending, compare at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_fwd.size() > 0) begin
        e = q_fwd.pop_front();
        chk("fwd.id_exec", f_exec, e.exec);
        chk("fwd.id_kill", f_kill, e.kill);
        chk("fwd.stall", f_stall, e.stall);
        chk("fwd.branch_taken", f_taken, e.taken);
        chk("fwd.sr", f_sr, e.sr);
        chk("fwd.exec_cnt", f_ec, e.ec);
        chk("fwd.kill_cnt", f_kc, e.kc);
      end
      if (q_stl.size() > 0) begin
        e = q_stl.pop_front();
        chk("stl.id_exec", s_exec, e.exec);
        chk("stl.id_kill", s_kill, e.kill);
        chk("stl.stall", s_stall, e.stall);
        chk("stl.branch_taken", s_taken, e.taken);
        chk("stl.sr", s_sr, e.sr);
        chk("stl.exec_cnt", s_ec, e.ec);
        chk("stl.kill_cnt", s_kc, e.kc);
      end
    end
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; id_valid = 1'b0; id_cond = 4'h0;
    id_is_branch = 1'b0; exe_valid = 1'b0; exe_s = 1'b0; exe_flags = 4'h0;
    // reset
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    // AL issues
    step(1, 4'hE, 0, 0, 0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // S-instr Z with dependent EQ: bypass vs one-cycle interlock
    step(1, 4'h0, 0, 1, 1, 4'b0100, 0, 1);
    step(1, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // sr = 1001, then GT issues and LE is killed
    step(0, 4'h0, 0, 1, 1, 4'b1001, 0, 1);
    step(1, 4'hC, 0, 0, 0, 4'h0, 0, 1);
    step(1, 4'hD, 0, 0, 0, 4'h0, 0, 1);
    step(1, 4'hF, 0, 0, 0, 4'h0, 0, 1);
    // taken branch then wrong-path slot
    step(1, 4'hE, 1, 0, 0, 4'h0, 0, 1);
    step(1, 4'hE, 0, 0, 0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // frozen S-instr leaves sr alone
    step(1, 4'hE, 0, 1, 1, 4'b1111, 1, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // reset asserted while interlock instance sits in WAIT
    step(1, 4'h2, 0, 1, 1, 4'b0010, 0, 1);
    step(1, 4'h2, 0, 0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // 17 issues: CW=4 counter wraps to 1
    for (int i = 0; i < 17; i++) step(1, 4'hE, 0, 0, 0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
    end
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 1);
    for (int i = 0; i < 20 && (q_fwd.size() > 0 || q_stl.size() > 0); i++) @(negedge clk);
    #1;
    if (q_fwd.size() > 0 || q_stl.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left, required 0", q_fwd.size() + q_stl.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
# cond_exec_ctrl

Conditional-execution controller for the 5-stage ARM pipeline. It sits between the ID and EXE stages and owns the architectural NZCV status register. For the instruction in ID it resolves the condition field against the most recent flags, and it either lets the instruction issue or annuls it into a bubble. It also raises the IF/ID flush on a taken branch and interlocks against flag-setting instructions still in EXE.

## Interface
Parameters:
- FWD, 1: 1 = bypass EXE flags into ID evaluation; 0 = stall one cycle instead.
- CW, 16: width of the executed/annulled event counters.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low.
- freeze  in  1  global pipeline hold (memory wait).
- id_valid  in  1  ID holds a real instruction.
- id_cond  in  4  ARM condition field of the ID instruction.
- id_is_branch  in  1  ID instruction is B/BL.
- exe_valid  in  1  EXE holds a real (non-annulled) instruction.
- exe_s  in  1  EXE instruction sets flags (S bit).
- exe_flags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- id_exec  out  1  ID instruction issues to EXE.
- id_kill  out  1  ID instruction annulled: ID/EXE must clear WB_EN, MEM_R, MEM_W and S.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EXE.
- branch_taken  out  1  taken branch in ID: redirect PC and flush IF/ID.
- sr  out  4  architectural {N,Z,C,V}.
- exec_cnt  out  CW  count of issued instructions.
- kill_cnt  out  CW  count of annulled instructions.

## Operation
- Condition decode uses {N,Z,C,V} = eff_flags:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: 0 (never).
- eff_flags:
  - If exe_valid&exe_s and FWD=1, eff_flags = exe_flags.
  - Otherwise eff_flags = sr.
- FSM states:
  - RUN:
    - Normal evaluation.
    - FWD=0 with id_valid&exe_valid&exe_s → stall=1, id_exec=id_kill=0, go WAIT.
    - Taken branch → go SQUASH.
  - WAIT:
    - sr now holds the EXE result; evaluate with sr.
    - Next state RUN, or SQUASH if the branch is taken.
  - SQUASH:
    - The ID slot holds the wrong-path instruction fetched behind the branch. Treat it as id_valid=0: no issue, no kill, no count.
    - Return to RUN.
- In RUN/WAIT with id_valid and no stall:
  - Condition true → id_exec=1.
  - Condition false → id_kill=1.
  - branch_taken = id_exec & id_is_branch.
- sr update: on posedge when exe_valid&exe_s&!freeze, sr ← exe_flags.
- Counters: increment on posedge when id_exec (respectively id_kill) and !freeze. Both wrap modulo 2^CW.
- freeze=1:
  - state, sr and counters hold.
  - Combinational outputs are still driven, but downstream ignores them.

## Timing
- Reset: state=RUN, sr=0000, exec_cnt=kill_cnt=0. With id_valid=0, all of id_exec, id_kill, stall and branch_taken are 0.
- id_exec, id_kill, stall and branch_taken are combinational from inputs and state. They are valid in the same cycle as the ID instruction (zero latency).
- Flag bypass (FWD=1): an S-instruction in EXE at cycle t governs the ID instruction at cycle t.
- Interlock (FWD=0): exactly 1 stall cycle; the dependent instruction issues or is killed at t+1.
- A taken branch at cycle t flushes IF/ID at the t→t+1 edge. Cycle t+1 is SQUASH.
- Simultaneous events:
  - SQUASH takes priority over stall; no stall is raised in SQUASH.
  - A WAIT-state branch flushes exactly as in RUN.
- Condition F never issues and counts as a kill. Condition E ignores the flags.
- If rst asserts mid-stall or mid-SQUASH, everything returns to reset values immediately (asynchronously).

## Structure
- Shared package arm_pkg holds:
  - cond-code localparams COND_EQ..COND_NV;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FSM state encoding ST_RUN, ST_WAIT, ST_SQUASH.
- One combinational sub-module, cond_eval (cond[3:0], flags[3:0] → pass). It is instantiated once on eff_flags.
- The FSM, sr and counters live in cond_exec_ctrl.

## Test plan
- Reset, then ID cond=E with id_valid=1 → id_exec=1, exec_cnt=1 after one edge. sr=0000 throughout.
- FWD=1: EXE S-instr with exe_flags=0100 (Z) and ID cond=0 (EQ) in the same cycle → id_exec=1, no stall. sr=0100 after the edge.
- FWD=0: same stimulus → stall=1 for one cycle. Next cycle id_exec=1; the EQ instruction issues exactly once.
- sr=1001 (N=V), ID cond=C (GT) → id_exec=1. ID cond=D (LE) → id_kill=1, kill_cnt increments.
- Taken branch (cond=E, id_is_branch=1) → branch_taken=1 that cycle. Next cycle is SQUASH: a valid ID instruction is neither issued nor killed, and the counters hold.
- Other directed checks:
  - freeze=1 during an S-instr → sr unchanged.
  - CW=4 with 17 issues → exec_cnt=1.
  - rst low mid-WAIT → state RUN, stall=0 immediately.
